// File: rtl/mist_spi_pkg.sv
// Shared types and constants for the MiST SPI command-channel target and its consumers.
package mist_spi_pkg;

  localparam int unsigned BIT_CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } state_e;

  localparam logic [7:0] CMD_BUTTONS     = 8'h01;
  localparam logic [7:0] CMD_JOY0        = 8'h02;
  localparam logic [7:0] CMD_JOY1        = 8'h03;
  localparam logic [7:0] CMD_PS2_KBD     = 8'h05;
  localparam logic [7:0] CMD_STATUS_STR  = 8'h14;
  localparam logic [7:0] CMD_STATUS_WORD = 8'h15;

endpackage

// File: rtl/spi_pin_sync.sv
// Synchronises raw SPI pins into clk and emits registered one-clk edge events on SCK and SS_n.
module spi_pin_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic spi_sck,
  input  logic spi_ss_n,
  input  logic spi_di,
  output logic rise,
  output logic fall,
  output logic ss_fall,
  output logic ss_rise,
  output logic di
);

  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic [SYNC_STAGES-1:0] di_sync_q, di_sync_d;
  logic sck_prev_q, sck_prev_d;
  logic ss_prev_q, ss_prev_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;
  logic ss_fall_q, ss_fall_d;
  logic ss_rise_q, ss_rise_d;
  logic di_q, di_d;

  always_comb begin
    sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
    ss_sync_d  = {ss_sync_q[SYNC_STAGES-2:0], spi_ss_n};
    di_sync_d  = {di_sync_q[SYNC_STAGES-2:0], spi_di};
    sck_prev_d = sck_sync_q[SYNC_STAGES-1];
    ss_prev_d  = ss_sync_q[SYNC_STAGES-1];
    rise_d     = sck_sync_q[SYNC_STAGES-1] & ~sck_prev_q;
    fall_d     = ~sck_sync_q[SYNC_STAGES-1] & sck_prev_q;
    ss_fall_d  = ss_prev_q & ~ss_sync_q[SYNC_STAGES-1];
    ss_rise_d  = ~ss_prev_q & ss_sync_q[SYNC_STAGES-1];
    di_d       = di_sync_q[SYNC_STAGES-1];
  end

  // Select resets to "asserted" so a transaction in flight at reset release
  // produces no ss_fall; a fresh select needs a deassert first.
  always_ff @(posedge clk) begin
    if (reset) begin
      sck_sync_q <= '0;
      ss_sync_q  <= '0;
      di_sync_q  <= '0;
      sck_prev_q <= 1'b0;
      ss_prev_q  <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      ss_fall_q  <= 1'b0;
      ss_rise_q  <= 1'b0;
      di_q       <= 1'b0;
    end else begin
      sck_sync_q <= sck_sync_d;
      ss_sync_q  <= ss_sync_d;
      di_sync_q  <= di_sync_d;
      sck_prev_q <= sck_prev_d;
      ss_prev_q  <= ss_prev_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      ss_fall_q  <= ss_fall_d;
      ss_rise_q  <= ss_rise_d;
      di_q       <= di_d;
    end
  end

  assign rise    = rise_q;
  assign fall    = fall_q;
  assign ss_fall = ss_fall_q;
  assign ss_rise = ss_rise_q;
  assign di      = di_q;

endmodule

// File: rtl/mist_spi_cmd_target.sv
// MiST SPI command-channel responder: deframes command/payload bytes (mode 0) and shifts responses out.
module mist_spi_cmd_target #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned IDX_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             spi_sck,
  input  logic             spi_ss_n,
  input  logic             spi_di,
  output logic             spi_do,
  output logic             spi_do_oe,
  output logic [7:0]       cmd,
  output logic             cmd_valid,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic [IDX_W-1:0] rx_index,
  input  logic [7:0]       tx_data,
  output logic             tx_load,
  output logic             busy
);

  import mist_spi_pkg::*;

  logic rise_s, fall_s, ss_fall_s, ss_rise_s, di_s;

  spi_pin_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_pin_sync (
    .clk     (clk),
    .reset   (reset),
    .spi_sck (spi_sck),
    .spi_ss_n(spi_ss_n),
    .spi_di  (spi_di),
    .rise    (rise_s),
    .fall    (fall_s),
    .ss_fall (ss_fall_s),
    .ss_rise (ss_rise_s),
    .di      (di_s)
  );

  state_e                 state_q, state_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [7:0]             rx_shift_q, rx_shift_d;
  logic [7:0]             cmd_q, cmd_d;
  logic [7:0]             rx_data_q, rx_data_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   cmd_valid_q, cmd_valid_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   tx_load_q, tx_load_d;
  logic [7:0]             tx_shift_q, tx_shift_d;
  logic [7:0]             tx_hold_q, tx_hold_d;
  logic                   tx_pend_q, tx_pend_d;
  logic [7:0]             rx_byte;
  logic                   byte_done;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    cmd_d       = cmd_q;
    rx_data_d   = rx_data_q;
    idx_d       = idx_q;
    cmd_valid_d = 1'b0;
    rx_valid_d  = 1'b0;
    tx_load_d   = 1'b0;
    tx_shift_d  = tx_shift_q;
    tx_hold_d   = tx_hold_q;
    tx_pend_d   = tx_pend_q;
    rx_byte     = {rx_shift_q[6:0], di_s};
    byte_done   = rise_s && (bit_cnt_q == '1);

    if (rx_valid_q) begin
      idx_d = idx_q + 1'b1;
    end

    // The first response byte must be on DO before the first rise, so it goes
    // straight to the shifter; later ones wait in tx_hold for the next fall.
    if (tx_load_q && (state_q != IDLE)) begin
      if (state_q == CMD) begin
        tx_shift_d = tx_data;
      end else begin
        tx_hold_d = tx_data;
        tx_pend_d = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (ss_fall_s) begin
          state_d    = CMD;
          bit_cnt_d  = '0;
          rx_shift_d = '0;
          tx_load_d  = 1'b1;
          tx_pend_d  = 1'b0;
        end
      end
      CMD, DATA: begin
        if (rise_s) begin
          rx_shift_d = rx_byte;
          bit_cnt_d  = bit_cnt_q + 1'b1;
          if (byte_done) begin
            tx_load_d = 1'b1;
            if (state_q == CMD) begin
              cmd_d       = rx_byte;
              cmd_valid_d = 1'b1;
              state_d     = DATA;
              idx_d       = '0;
            end else begin
              rx_data_d  = rx_byte;
              rx_valid_d = 1'b1;
            end
          end
        end
        if (fall_s) begin
          if (tx_pend_q) begin
            tx_shift_d = tx_hold_q;
            tx_pend_d  = 1'b0;
          end else begin
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
          end
        end
        // Evaluated after the rise so a byte completing on the deassert clk still reports.
        if (ss_rise_s) begin
          state_d   = IDLE;
          tx_pend_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      cmd_q       <= '0;
      rx_data_q   <= '0;
      idx_q       <= '0;
      cmd_valid_q <= 1'b0;
      rx_valid_q  <= 1'b0;
      tx_load_q   <= 1'b0;
      tx_shift_q  <= '0;
      tx_hold_q   <= '0;
      tx_pend_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      cmd_q       <= cmd_d;
      rx_data_q   <= rx_data_d;
      idx_q       <= idx_d;
      cmd_valid_q <= cmd_valid_d;
      rx_valid_q  <= rx_valid_d;
      tx_load_q   <= tx_load_d;
      tx_shift_q  <= tx_shift_d;
      tx_hold_q   <= tx_hold_d;
      tx_pend_q   <= tx_pend_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign spi_do_oe = busy;
  assign spi_do    = busy & tx_shift_q[7];
  assign cmd       = cmd_q;
  assign cmd_valid = cmd_valid_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign rx_index  = idx_q;
  assign tx_load   = tx_load_q;

endmodule
